// File: rtl/banked_read_mux.sv
// Banked register file with a registered read port; reads return one cycle after acceptance.
// A held response stalls new reads (OUT_rready low) until the consumer takes it.
module banked_read_mux #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int BANKS   = 2,
  parameter int DEFAULT = 42,
  localparam int ENTRIES = BANKS * DEPTH,
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_wen,
  input  logic [AW-1:0]    IN_waddr,
  input  logic [WIDTH-1:0] IN_wdata,
  input  logic             IN_rvalid,
  input  logic [AW-1:0]    IN_raddr,
  output logic             OUT_rready,
  output logic             OUT_rvalid,
  output logic [WIDTH-1:0] OUT_rdata,
  input  logic             IN_ready
);

  // One extra address bit so DEPTH and ENTRIES are representable even when ENTRIES == 2**AW.
  localparam int AX = AW + 1;
  localparam logic [WIDTH-1:0] DEF_W   = WIDTH'(DEFAULT);
  localparam logic [AX-1:0]    DEPTH_X = AX'(DEPTH);
  localparam logic [AX-1:0]    ENT_X   = AX'(ENTRIES);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] mem_d [ENTRIES];
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [AX-1:0]    raddr_x, waddr_x, bank_sel, entry_sel;
  logic [WIDTH-1:0] bank_word [BANKS];
  logic [WIDTH-1:0] rd_word;
  logic             accept, wr_hit, bypass;

  assign raddr_x    = {1'b0, IN_raddr};
  assign waddr_x    = {1'b0, IN_waddr};
  assign bank_sel   = raddr_x / DEPTH_X;
  assign entry_sel  = raddr_x % DEPTH_X;
  assign wr_hit     = IN_wen && (waddr_x < ENT_X);
  assign bypass     = wr_hit && (IN_waddr == IN_raddr);
  assign OUT_rready = !rvalid_q || IN_ready;
  assign accept     = IN_rvalid && OUT_rready;
  assign OUT_rvalid = rvalid_q;
  assign OUT_rdata  = rdata_q;

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      bank_word[b] = DEF_W;
      for (int e = 0; e < DEPTH; e++) begin
        if (entry_sel == AX'(e)) bank_word[b] = mem_q[b*DEPTH + e];
      end
    end
  end

  // Out-of-range addresses decode to a bank index >= BANKS and fall through to DEFAULT.
  always_comb begin
    rd_word = DEF_W;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_sel == AX'(b)) rd_word = bank_word[b];
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (wr_hit && (waddr_x == AX'(i))) mem_d[i] = IN_wdata;
    end
    rvalid_d = accept || (rvalid_q && !IN_ready);
    rdata_d  = rdata_q;
    if (accept) rdata_d = bypass ? IN_wdata : rd_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= DEF_W;
      rvalid_q <= 1'b0;
      rdata_q  <= DEF_W;
    end else begin
      mem_q    <= mem_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_banked_read_mux.sv
// Scoreboard bench for banked_read_mux: default 2x4 instance (a) and a 3x3 instance (b).
module tb_banked_read_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_wen, a_rv, a_ready, a_rready, a_ovld;
  logic [2:0]  a_waddr, a_raddr;
  logic [31:0] a_wdata, a_odata;

  logic        b_rst, b_wen, b_rv, b_ready, b_rready, b_ovld;
  logic [3:0]  b_waddr, b_raddr;
  logic [31:0] b_wdata, b_odata;

  banked_read_mux u_a (
    .clk(clk), .rst(a_rst), .IN_wen(a_wen), .IN_waddr(a_waddr), .IN_wdata(a_wdata),
    .IN_rvalid(a_rv), .IN_raddr(a_raddr), .OUT_rready(a_rready), .OUT_rvalid(a_ovld),
    .OUT_rdata(a_odata), .IN_ready(a_ready)
  );

  banked_read_mux #(.BANKS(3), .DEPTH(3)) u_b (
    .clk(clk), .rst(b_rst), .IN_wen(b_wen), .IN_waddr(b_waddr), .IN_wdata(b_wdata),
    .IN_rvalid(b_rv), .IN_raddr(b_raddr), .OUT_rready(b_rready), .OUT_rvalid(b_ovld),
    .OUT_rdata(b_odata), .IN_ready(b_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] sb_a[$];
  logic [31:0] sb_b[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pop one expectation per delivered response (valid && ready at the falling edge).
  always @(negedge clk) begin
    if (!a_rst && a_ovld && a_ready) begin
      if (sb_a.size() == 0) check("a_unexpected_rsp", 32'(sb_a.size()), 1);
      else check("a_rdata", a_odata, sb_a.pop_front());
    end
    if (!b_rst && b_ovld && b_ready) begin
      if (sb_b.size() == 0) check("b_unexpected_rsp", 32'(sb_b.size()), 1);
      else check("b_rdata", b_odata, sb_b.pop_front());
    end
  end

  task automatic rd(input bit sel, input logic [3:0] addr, input logic [31:0] exp);
    int t = 0;
    if (sel) begin b_rv = 1'b1; b_raddr = addr; end
    else begin a_rv = 1'b1; a_raddr = addr[2:0]; end
    @(negedge clk);
    while (!(sel ? b_rready : a_rready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!(sel ? b_rready : a_rready)) check("accept_timeout", 32'(sel ? b_rready : a_rready), 1);
    else if (sel) sb_b.push_back(exp);
    else sb_a.push_back(exp);
    @(posedge clk); #1;
    check(sel ? "b_latency" : "a_latency", 32'(sel ? b_ovld : a_ovld), 1);
    if (sel) b_rv = 1'b0; else a_rv = 1'b0;
  endtask

  task automatic wr(input bit sel, input logic [3:0] addr, input logic [31:0] d);
    if (sel) begin b_wen = 1'b1; b_waddr = addr; b_wdata = d; end
    else begin a_wen = 1'b1; a_waddr = addr[2:0]; a_wdata = d; end
    @(posedge clk); #1;
    if (sel) b_wen = 1'b0; else a_wen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    // Reset with a write and read presented; both must be discarded.
    a_rst = 1; a_wen = 1; a_waddr = 0; a_wdata = 32'h1234; a_rv = 1; a_raddr = 0; a_ready = 1;
    b_rst = 1; b_wen = 0; b_waddr = 0; b_wdata = 0; b_rv = 0; b_raddr = 0; b_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 0; b_rst = 0; a_wen = 0; a_rv = 0;
    check("a_rst_rvalid", 32'(a_ovld), 0);
    check("a_rst_rdata", a_odata, 42);
    check("b_rst_rvalid", 32'(b_ovld), 0);

    for (int k = 0; k < 8; k++) rd(0, 4'(k), 42);
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) wr(0, 4'(k), 32'h1000 + k);
    c0 = cyc;
    for (int k = 0; k < 8; k++) rd(0, 4'(k), 32'h1000 + k);
    check("a_b2b_cycles", 32'(cyc - c0), 8);

    // Same-cycle write and read of one address returns the new data.
    a_wen = 1; a_waddr = 5; a_wdata = 32'hDEADBEEF;
    rd(0, 5, 32'hDEADBEEF);
    a_wen = 0;
    rd(0, 5, 32'hDEADBEEF);

    // Backpressure: held response must survive writes to its address.
    rd(0, 2, 32'h1002);
    a_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_wen = 1; a_waddr = 2; a_wdata = 32'hAAAA; a_rv = 1; a_raddr = 3;
      @(negedge clk);
      check("a_hold_rvalid", 32'(a_ovld), 1);
      check("a_hold_rdata", a_odata, 32'h1002);
      check("a_hold_rready", 32'(a_rready), 0);
      @(posedge clk); #1;
    end
    a_wen = 0; a_rv = 0;
    check("a_hold_rdata_end", a_odata, 32'h1002);
    a_ready = 1;
    rd(0, 3, 32'h1003);
    rd(0, 2, 32'hAAAA);

    // Reset while a response is pending under backpressure.
    rd(0, 1, 32'h1001);
    a_ready = 0;
    @(negedge clk);
    check("a_pending_rvalid", 32'(a_ovld), 1);
    a_rst = 1;
    @(posedge clk); #1;
    a_rst = 0;
    sb_a.delete();
    check("a_midrst_rvalid", 32'(a_ovld), 0);
    check("a_midrst_rdata", a_odata, 42);
    a_ready = 1;
    for (int k = 0; k < 8; k++) rd(0, 4'(k), 42);

    // 3 banks x 3 entries: out-of-range reads/writes and bank/entry decode.
    rd(1, 9, 42);
    rd(1, 15, 42);
    wr(1, 12, 32'h12121212);
    rd(1, 12, 42);
    b_wen = 1; b_waddr = 12; b_wdata = 32'h0BAD0BAD;
    rd(1, 12, 42);
    b_wen = 0;
    wr(1, 7, 32'h7777);
    wr(1, 3, 32'h3333);
    rd(1, 7, 32'h7777);
    rd(1, 3, 32'h3333);
    rd(1, 4, 42);
    rd(1, 8, 42);

    repeat (3) @(posedge clk);
    #1;
    check("a_sb_drained", 32'(sb_a.size()), 0);
    check("b_sb_drained", 32'(sb_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_read_mux.md
BANKED_READ_MUX -- requirements
Module: banked_read_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: entries per bank, >=1.
REQ-003 SHALL have parameter BANKS, default 2: bank count, >=1.
REQ-004 SHALL have parameter DEFAULT, default 42: reset and out-of-range value, truncated to WIDTH.
REQ-005 SHALL define localparam ENTRIES = BANKS*DEPTH and AW = max(1, clog2(ENTRIES)).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 IN_wen  input  1  write enable.
REQ-009 IN_waddr  input  AW  write address; flat index = bank*DEPTH + entry.
REQ-010 IN_wdata  input  WIDTH  write data.
REQ-011 IN_rvalid  input  1  read request valid.
REQ-012 IN_raddr  input  AW  read address, same encoding as IN_waddr.
REQ-013 OUT_rready  output  1  read request accepted this cycle.
REQ-014 OUT_rvalid  output  1  read response valid.
REQ-015 OUT_rdata  output  WIDTH  read response data.
REQ-016 IN_ready  input  1  consumer accepts response.

Function
REQ-017 Storage: ENTRIES registers of WIDTH bits; the read path SHALL decode IN_raddr into a bank select (raddr / DEPTH) and an entry select (raddr % DEPTH), implemented as a two-level mux: entry mux per bank, then bank mux.
REQ-018 Write: when IN_wen=1 and IN_waddr < ENTRIES, entry IN_waddr SHALL take IN_wdata at the clock edge; IN_waddr >= ENTRIES SHALL be ignored with no state change.
REQ-019 Handshake: OUT_rready SHALL equal (!OUT_rvalid || IN_ready), combinationally; a read is accepted when IN_rvalid && OUT_rready.
REQ-020 Latency: an accepted read SHALL set OUT_rvalid=1 and load OUT_rdata on the next edge (1-cycle latency).
REQ-021 Response drain: when OUT_rvalid && IN_ready and no new read is accepted, OUT_rvalid SHALL clear on the next edge.
REQ-022 Backpressure: while OUT_rvalid=1 and IN_ready=0, OUT_rvalid and OUT_rdata SHALL hold unchanged, including across writes to the held address.
REQ-023 Throughput: with IN_ready=1 continuously, one read SHALL be accepted per cycle.
REQ-024 Bypass: a read accepted in the same cycle as a write to the same in-range address SHALL return the new IN_wdata.
REQ-025 Out-of-range read: IN_raddr >= ENTRIES SHALL be accepted normally and return DEFAULT.
REQ-026 Degenerate ENTRIES=1: all in-range addresses map to entry 0; AW=1, address 1 is out of range.
REQ-027 No combinational path SHALL exist from IN_raddr/IN_wdata to OUT_rdata.

Reset
REQ-028 While rst=1 at an edge: all entries SHALL load DEFAULT, OUT_rvalid SHALL be 0 and OUT_rdata SHALL be DEFAULT; writes and reads presented in that cycle SHALL be discarded.
REQ-029 Reset asserted mid-operation (response held under backpressure) SHALL drop the pending response; OUT_rvalid=0 in the cycle after reset.
REQ-030 OUT_rready SHALL follow REQ-019 during reset; its value there is don't-care for the bench.

Verification
REQ-031 Reset then read all 8 addresses (defaults) with IN_ready=1 -> OUT_rdata=42 for each, OUT_rvalid one cycle after each accept.
REQ-032 Write addr k data 0x1000+k for k=0..7, then read raddr 0..7 back-to-back -> responses 0x1000..0x1007 in order, one per cycle, no gaps.
REQ-033 Same-cycle write addr 5 data 0xDEADBEEF and read addr 5 -> next cycle OUT_rdata=0xDEADBEEF.
REQ-034 Read addr 2 (holding 0x1002), drop IN_ready for 3 cycles while writing 0xAAAA to addr 2 -> OUT_rdata stays 0x1002, OUT_rready=0, next read not accepted until IN_ready=1.
REQ-035 BANKS=3, DEPTH=3 (AW=4): read addr 9 and 15 -> 42; write addr 12 then read 12 -> 42 (write ignored); read addr 7 returns bank 2 entry 1.
REQ-036 Pending response under backpressure, assert rst one cycle -> OUT_rvalid=0, all entries read back 42 afterwards.
